// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson counter phase monitor.
//   state_t      : monitor FSM states (SYNC, LOCKED, ERROR)
//   ERR_*        : err_code encodings
//   phase_w()    : width of a phase index for a given Johnson code width
package johnson_pkg;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    LOCKED = 2'd1,
    ERROR  = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TRANS   = 2'b10;

  // A WIDTH-bit Johnson counter has 2*WIDTH states.
  function automatic int phase_w(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson code decoder.
//   code  in  WIDTH         Johnson code, bit 0 = first stage
//   legal out 1             code is one of the 2*WIDTH valid states
//   phase out phase_w(WIDTH) phase index of the code (0 when illegal)
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0]          code,
  output logic                      legal,
  output logic [phase_w(WIDTH)-1:0] phase
);

  localparam int NPH = 2 * WIDTH;
  localparam int PW  = phase_w(WIDTH);
  localparam logic [WIDTH-1:0] ONES = '1;

  // Phases 0..WIDTH fill with ones from bit 0; later phases drain them
  // from bit 0 upward.
  function automatic logic [WIDTH-1:0] pattern(input int k);
    if (k <= WIDTH) return WIDTH'((32'd1 << k) - 32'd1);
    else            return ONES << (k - WIDTH);
  endfunction

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; without them
    // an unmatched code would infer a latch.
    legal = 1'b0;
    phase = '0;
    for (int k = 0; k < NPH; k++) begin
      if (code == pattern(k)) begin
        legal = 1'b1;
        phase = PW'(k);
      end
    end
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Johnson counter phase monitor.
// Captures the upstream Johnson code, decodes it to a phase, checks that each
// clock advances exactly one step, locks after LOCK_COUNT good steps, counts
// revolutions and flags illegal codes / bad transitions with a sticky error.
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   jc_in        in   Johnson code from upstream counter
//   clr_err      in   clears the sticky error (only acted on in ERROR)
//   phase        out  last legally decoded phase index
//   phase_onehot out  one-hot of phase while phase_valid, else zero
//   phase_valid  out  high in LOCKED
//   wrap         out  one-cycle pulse on a locked last->0 step
//   rev_count    out  wrap pulse count, modulo 2^REV_W
//   err          out  sticky fault flag
//   err_code     out  fault cause (ERR_NONE / ERR_ILLEGAL / ERR_TRANS)
module johnson_phase_monitor
  import johnson_pkg::*;
#(
  parameter int WIDTH      = 3,
  parameter int LOCK_COUNT = 2,
  parameter int REV_W      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          jc_in,
  input  logic                      clr_err,
  output logic [phase_w(WIDTH)-1:0] phase,
  output logic [2*WIDTH-1:0]        phase_onehot,
  output logic                      phase_valid,
  output logic                      wrap,
  output logic [REV_W-1:0]          rev_count,
  output logic                      err,
  output logic [1:0]                err_code
);

  localparam int NPH = 2 * WIDTH;
  localparam int PW  = phase_w(WIDTH);
  localparam logic [PW-1:0]  PH_LAST   = PW'(NPH - 1);
  localparam logic [3:0]     LOCK_LAST = 4'(LOCK_COUNT - 1);
  localparam logic [NPH-1:0] OH_ZERO   = NPH'(1);

  // Stage 1 capture
  logic [WIDTH-1:0] jc_q;
  logic             jc_vld;

  // Stage 2 state
  state_t           state;
  logic             prev_vld;
  logic [3:0]       lock_cnt;

  logic             dec_legal;
  logic [PW-1:0]    dec_phase;
  logic [PW-1:0]    succ;
  logic             is_succ;

  function automatic logic [NPH-1:0] onehot(input logic [PW-1:0] p);
    return OH_ZERO << p;
  endfunction

  always_ff @(posedge clk) begin
    // NOTE: registered state is always written with <=, so every flop sees
    // the pre-edge values of the others regardless of statement order.
    if (reset) begin
      jc_q   <= '0;
      jc_vld <= 1'b0;
    end else begin
      jc_q   <= jc_in;
      jc_vld <= 1'b1;
    end
  end

  johnson_decode #(.WIDTH(WIDTH)) u_decode (
    .code  (jc_q),
    .legal (dec_legal),
    .phase (dec_phase)
  );

  // The phase register doubles as the reference for the next transition.
  assign succ    = (phase == PH_LAST) ? '0 : phase + PW'(1);
  assign is_succ = prev_vld && dec_legal && (dec_phase == succ);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= SYNC;
      prev_vld     <= 1'b0;
      lock_cnt     <= '0;
      phase        <= '0;
      phase_onehot <= '0;
      phase_valid  <= 1'b0;
      wrap         <= 1'b0;
      rev_count    <= '0;
      err          <= 1'b0;
      err_code     <= ERR_NONE;
    end else begin
      wrap <= 1'b0;
      unique case (state)
        SYNC: begin
          if (jc_vld) begin
            if (!dec_legal) begin
              // Tolerated while hunting; forget the reference.
              prev_vld <= 1'b0;
              lock_cnt <= '0;
            end else begin
              phase    <= dec_phase;
              prev_vld <= 1'b1;
              if (is_succ) begin
                lock_cnt <= lock_cnt + 4'd1;
                if (lock_cnt == LOCK_LAST) begin
                  state        <= LOCKED;
                  phase_valid  <= 1'b1;
                  phase_onehot <= onehot(dec_phase);
                end
              end else begin
                lock_cnt <= '0;
              end
            end
          end
        end

        LOCKED: begin
          if (!dec_legal) begin
            state        <= ERROR;
            err          <= 1'b1;
            err_code     <= ERR_ILLEGAL;
            phase_valid  <= 1'b0;
            phase_onehot <= '0;
          end else begin
            phase <= dec_phase;
            if (is_succ) begin
              phase_onehot <= onehot(dec_phase);
              if (phase == PH_LAST) begin
                wrap      <= 1'b1;
                rev_count <= rev_count + REV_W'(1);
              end
            end else begin
              // Stall, reversal or skip: upstream must advance every cycle.
              state        <= ERROR;
              err          <= 1'b1;
              err_code     <= ERR_TRANS;
              phase_valid  <= 1'b0;
              phase_onehot <= '0;
            end
          end
        end

        ERROR: begin
          // Phase and the first fault cause hold until cleared.
          if (clr_err) begin
            state    <= SYNC;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            lock_cnt <= '0;
            prev_vld <= 1'b0;
          end
        end

        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Directed bench for johnson_phase_monitor (WIDTH=3, LOCK_COUNT=2).
// Two instances share stimulus: dut (REV_W=8) and dut2 (REV_W=2).
module tb_johnson_phase_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr_err;
  logic [2:0] jc_in;

  logic [2:0] phase;
  logic [5:0] phase_onehot;
  logic       phase_valid, wrap, err;
  logic [7:0] rev_count;
  logic [1:0] err_code;

  logic [2:0] phase2;
  logic [5:0] phase_onehot2;
  logic       phase_valid2, wrap2, err2;
  logic [1:0] rev_count2;
  logic [1:0] err_code2;

  logic [2:0] codes [6] = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b110, 3'b100};

  int up_ph;
  int n_checks = 0;
  int n_errors = 0;
  int exp_rev;

  always #5 clk = ~clk;

  johnson_phase_monitor #(.WIDTH(3), .LOCK_COUNT(2), .REV_W(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .jc_in        (jc_in),
    .clr_err      (clr_err),
    .phase        (phase),
    .phase_onehot (phase_onehot),
    .phase_valid  (phase_valid),
    .wrap         (wrap),
    .rev_count    (rev_count),
    .err          (err),
    .err_code     (err_code)
  );

  johnson_phase_monitor #(.WIDTH(3), .LOCK_COUNT(2), .REV_W(2)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .jc_in        (jc_in),
    .clr_err      (clr_err),
    .phase        (phase2),
    .phase_onehot (phase_onehot2),
    .phase_valid  (phase_valid2),
    .wrap         (wrap2),
    .rev_count    (rev_count2),
    .err          (err2),
    .err_code     (err_code2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Upstream counter advances one step.
  task automatic adv();
    up_ph = (up_ph + 1) % 6;
    jc_in = codes[up_ph];
  endtask

  task automatic do_reset(input int n);
    reset   = 1'b1;
    clr_err = 1'b0;
    up_ph   = 0;
    jc_in   = codes[0];
    repeat (n) tick();
    check("rst_phase",  phase,        0);
    check("rst_onehot", phase_onehot, 0);
    check("rst_valid",  phase_valid,  0);
    check("rst_wrap",   wrap,         0);
    check("rst_rev",    rev_count,    0);
    check("rst_err",    err,          0);
    check("rst_code",   err_code,     0);
    check("rst_rev2",   rev_count2,   0);
    check("rst_err2",   err2,         0);
    reset   = 1'b0;
    exp_rev = 0;
  endtask

  // Counter and monitor leave reset together: lock shows at edge 4, phase 2.
  task automatic lock_in();
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e == 3) begin
        check("lock_e3_valid", phase_valid, 0);
        check("lock_e3_phase", phase,       1);
      end
      if (e == 4) begin
        check("lock_e4_valid",  phase_valid,  1);
        check("lock_e4_phase",  phase,        2);
        check("lock_e4_onehot", phase_onehot, 6'b000100);
        check("lock_e4_valid2", phase_valid2, 1);
      end
      adv();
    end
  endtask

  task automatic run_to(input int t);
    int guard = 0;
    while (up_ph != t && guard < 12) begin
      tick();
      adv();
      guard++;
    end
    if (up_ph != t) check("run_to_bound", up_ph, t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp_ph;
    reset   = 1'b1;
    clr_err = 1'b0;
    jc_in   = 3'b000;

    // Reset and lock-in
    do_reset(2);
    lock_in();

    // Free run: five revolutions; dut2 rev sequence 1,2,3,0,1
    for (int e = 5; e <= 33; e++) begin
      tick();
      exp_ph = (e - 2) % 6;
      if (exp_ph == 0) exp_rev++;
      check("run_phase", phase,       exp_ph);
      check("run_valid", phase_valid, 1);
      check("run_wrap",  wrap,        (exp_ph == 0) ? 1 : 0);
      check("run_rev",   rev_count,   exp_rev);
      check("run_wrap2", wrap2,       (exp_ph == 0) ? 1 : 0);
      check("run_rev2",  rev_count2,  exp_rev % 4);
      if (e == 7) check("run_onehot", phase_onehot, 6'b100000);
      adv();
    end

    // Illegal code 010 for one cycle
    run_to(5);
    tick();
    check("ill_pre_phase", phase, 4);
    jc_in = 3'b010;
    tick();
    check("ill_pre2_phase", phase,       5);
    check("ill_pre2_valid", phase_valid, 1);
    up_ph = 1;
    jc_in = codes[1];
    tick();
    check("ill_err",    err,          1);
    check("ill_code",   err_code,     2'b01);
    check("ill_valid",  phase_valid,  0);
    check("ill_onehot", phase_onehot, 0);
    check("ill_phase",  phase,        5);
    check("ill_wrap",   wrap,         0);
    repeat (3) begin
      adv();
      tick();
    end
    check("ill_sticky_err",   err,       1);
    check("ill_sticky_code",  err_code,  2'b01);
    check("ill_sticky_phase", phase,     5);
    check("ill_sticky_rev",   rev_count, 5);

    // Reset in ERROR with rev_count=5, then relock
    do_reset(1);
    lock_in();

    // clr_err in LOCKED is ignored
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    adv();
    check("clr_lk_valid", phase_valid, 1);
    check("clr_lk_err",   err,         0);
    check("clr_lk_phase", phase,       3);

    // Stall: hold 011 for two cycles
    run_to(2);
    tick();
    check("stall_pre_phase", phase, 1);
    tick();
    check("stall_pre2_phase", phase,       2);
    check("stall_pre2_valid", phase_valid, 1);
    adv();
    tick();
    check("stall_err",   err,         1);
    check("stall_code",  err_code,    2'b10);
    check("stall_valid", phase_valid, 0);
    check("stall_phase", phase,       2);

    // Clear with a good stream and relock
    adv();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clr_err",   err,         0);
    check("clr_code",  err_code,    0);
    check("clr_valid", phase_valid, 0);
    check("clr_phase", phase,       2);
    adv();
    tick();
    check("relock_e_valid", phase_valid, 0);
    check("relock_e_phase", phase,       4);
    adv();
    tick();
    check("relock_f_valid", phase_valid, 0);
    check("relock_f_phase", phase,       5);
    adv();
    tick();
    check("relock_g_valid",  phase_valid,  1);
    check("relock_g_phase",  phase,        0);
    check("relock_g_wrap",   wrap,         0);
    check("relock_g_onehot", phase_onehot, 6'b000001);
    check("relock_g_rev",    rev_count,    1);
    check("relock_g_rev2",   rev_count2,   1);
    adv();

    // Reversal 111 -> 011
    run_to(3);
    tick();
    check("rev_pre_phase", phase, 2);
    up_ph = 2;
    jc_in = codes[2];
    tick();
    check("rev_pre2_phase", phase,       3);
    check("rev_pre2_valid", phase_valid, 1);
    adv();
    tick();
    check("rev_err",   err,      1);
    check("rev_code",  err_code, 2'b10);
    check("rev_phase", phase,    2);

    // clr_err together with a new (illegal) code in ERROR: clear wins
    jc_in   = 3'b010;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("clrfault_err",  err,      0);
    check("clrfault_code", err_code, 0);
    up_ph = 4;
    jc_in = codes[4];
    tick();
    check("sync_ill_err",   err,         0);
    check("sync_ill_valid", phase_valid, 0);
    check("sync_ill_phase", phase,       2);
    adv();
    tick();
    check("sync_ref_phase", phase, 4);
    adv();
    tick();
    check("sync_s1_valid", phase_valid, 0);
    adv();
    tick();
    check("sync_lock_valid", phase_valid, 1);
    check("sync_lock_phase", phase,       0);

    // Illegal code where a step would otherwise be taken: cause 01
    up_ph = 2;
    jc_in = 3'b010;
    tick();
    check("ill2_pre_phase", phase, 1);
    up_ph = 3;
    jc_in = codes[3];
    tick();
    check("ill2_err",   err,      1);
    check("ill2_code",  err_code, 2'b01);
    check("ill2_phase", phase,    1);
    check("ill2_code2", err_code2, 2'b01);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
